// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter: round-robin between pipeline writeback and debug loader,
// plus a full register dump sequencer. Define REGARB_ZERO_FILTER_EN to drop writes to x0.
module regfile_wr_arbiter #(
    parameter int NUM_REGS = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_WB_VALID,
    input  logic [4:0]  I_WB_RD,
    input  logic [31:0] I_WB_DATA,
    output logic        O_WB_READY,
    input  logic        I_DBG_VALID,
    input  logic [4:0]  I_DBG_RD,
    input  logic [31:0] I_DBG_DATA,
    output logic        O_DBG_READY,
    input  logic        I_DUMP_START,
    output logic        O_DUMP_BUSY,
    output logic        O_DUMP_VALID,
    output logic [4:0]  O_DUMP_IDX,
    output logic [31:0] O_DUMP_DATA,
    output logic [4:0]  O_REGMEM_RD,
    output logic [31:0] O_REGMEM_WRITE_DATA,
    output logic        O_REGMEM_REGWR,
    output logic [4:0]  O_REGMEM_RS,
    input  logic [31:0] I_REGMEM_READ_DATA_1
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_SCAN  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      r_state;
    logic        r_ptr;          // 0: writeback has priority, 1: debug has priority
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_dump_valid;
    logic [4:0]  r_dump_idx;
    logic [31:0] r_dump_data;
    logic        r_regwr;
    logic [4:0]  r_rd;
    logic [31:0] r_wdata;

    logic        w_open;
    logic        w_wb_gnt;
    logic        w_dbg_gnt;
    logic        w_acc;
    logic        w_wr_en;
    logic [4:0]  w_rd;
    logic [31:0] w_data;

    // Grants only open in IDLE and not on the cycle a dump is requested.
    always_comb begin
        w_open    = (r_state == S_IDLE) && !I_DUMP_START;
        w_wb_gnt  = w_open && I_WB_VALID && (!I_DBG_VALID || !r_ptr);
        w_dbg_gnt = w_open && I_DBG_VALID && (!I_WB_VALID || r_ptr);
        w_acc     = w_wb_gnt || w_dbg_gnt;
        w_rd      = w_wb_gnt ? I_WB_RD : I_DBG_RD;
        w_data    = w_wb_gnt ? I_WB_DATA : I_DBG_DATA;
`ifdef REGARB_ZERO_FILTER_EN
        w_wr_en   = w_acc && (w_rd != 5'd0);
`else
        w_wr_en   = w_acc;
`endif
    end

    assign O_WB_READY  = w_wb_gnt;
    assign O_DBG_READY = w_dbg_gnt;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_regwr <= 1'b0;
            r_rd    <= 5'd0;
            r_wdata <= 32'd0;
            r_ptr   <= 1'b0;
        end else begin
            r_regwr <= w_wr_en;
            if (w_wr_en) begin
                r_rd    <= w_rd;
                r_wdata <= w_data;
            end
            if (w_acc)
                r_ptr <= w_wb_gnt;
        end
    end

    // Dump sequencer; FLUSH gives the last registered write one edge to land in the file.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state      <= S_IDLE;
            r_cnt        <= 5'd0;
            r_busy       <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_idx   <= 5'd0;
            r_dump_data  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dump_valid <= 1'b0;
                    if (I_DUMP_START) begin
                        r_state <= S_FLUSH;
                        r_busy  <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_cnt   <= 5'd0;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    r_dump_data  <= I_REGMEM_READ_DATA_1;
                    r_dump_idx   <= r_cnt;
                    r_dump_valid <= 1'b1;
                    r_cnt        <= r_cnt + 5'd1;
                    if (r_cnt == LAST_IDX)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_dump_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign O_REGMEM_RS         = (r_state == S_SCAN) ? r_cnt : 5'd0;
    assign O_REGMEM_RD         = r_rd;
    assign O_REGMEM_WRITE_DATA = r_wdata;
    assign O_REGMEM_REGWR      = r_regwr;
    assign O_DUMP_BUSY         = r_busy;
    assign O_DUMP_VALID        = r_dump_valid;
    assign O_DUMP_IDX          = r_dump_idx;
    assign O_DUMP_DATA         = r_dump_data;

endmodule
